// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// State encoding, access width codes and the timeout read-data value.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;
  localparam int          CNT_W    = 16;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner select: req_i + ptr_i (last granted) -> one-hot win_o.
// MEM_ARB_ROUND_ROBIN_EN: round robin on ties; otherwise m0 has fixed priority.
module mem_arb_select (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] win_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // ptr_i names the master granted last; the other one wins a tie.
  always_comb begin
    win_o = 2'b00;
    if (&req_i)
      win_o = ptr_i ? 2'b01 : 2'b10;
    else
      win_o = req_i;
  end
`else
  // Pointer has no load here and is trimmed away.
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    win_o = 2'b00;
    priority case (1'b1)
      req_i[0]: win_o = 2'b01;
      req_i[1]: win_o = 2'b10;
      default:  win_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter: IDLE -> ACCESS -> DONE, all outputs
// registered. Ports: clk/reset; per-master req/we/width/addr/wdata; rdata,
// ack, err, grant, busy back to masters; s_req/s_we/s_width/s_addr/s_wdata out
// and s_rdata/s_ack in on the slave side. TIMEOUT_CYCLES=0 waits forever.
// Build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  width,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [31:0] rdata,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic        s_req,
  output logic        s_we,
  output logic [1:0]  s_width,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [1:0]         grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               s_req_q, s_req_d;
  logic               s_we_q, s_we_d;
  logic [1:0]         s_width_q, s_width_d;
  logic [31:0]        s_addr_q, s_addr_d;
  logic [31:0]        s_wdata_q, s_wdata_d;
  logic [1:0]         win;
  logic               tmo;

  mem_arb_select u_sel (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  // Fires on the ACCESS cycle that would make the count reach the limit.
  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (32'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rdata_d   = rdata_q;
    ack_d     = ack_q;
    err_d     = err_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_width_d = s_width_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_ACCESS;
          cnt_d     = '0;
          ptr_d     = win[1];
          grant_d   = win;
          busy_d    = 1'b1;
          s_req_d   = 1'b1;
          s_we_d    = win[1] ? we[1] : we[0];
          s_width_d = win[1] ? width[3:2] : width[1:0];
          s_addr_d  = win[1] ? addr[63:32] : addr[31:0];
          s_wdata_d = win[1] ? wdata[63:32] : wdata[31:0];
        end
      end
      ST_ACCESS: begin
        if (s_ack) begin
          state_d = ST_DONE;
          s_req_d = 1'b0;
          rdata_d = s_rdata;
          ack_d   = grant_q;
        end else if (tmo) begin
          state_d = ST_DONE;
          s_req_d = 1'b0;
          rdata_d = ERR_DATA;
          ack_d   = grant_q;
          err_d   = grant_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        grant_d = 2'b00;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b1;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_width_q <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_width_q <= s_width_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_width = s_width_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: u_dut uses a 4-cycle timeout, u_nt has
// the timeout disabled and shares all inputs.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [3:0]  width;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [31:0] rdata, n_rdata;
  logic [1:0]  ack, n_ack;
  logic [1:0]  err, n_err;
  logic        s_req, n_s_req;
  logic        s_we, n_s_we;
  logic [1:0]  s_width, n_s_width;
  logic [31:0] s_addr, n_s_addr;
  logic [31:0] s_wdata, n_s_wdata;
  logic [1:0]  grant, n_grant;
  logic        busy, n_busy;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .width(width), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err),
    .s_req(s_req), .s_we(s_we), .s_width(s_width),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .busy(busy)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(0)) u_nt (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .width(width), .addr(addr), .wdata(wdata),
    .rdata(n_rdata), .ack(n_ack), .err(n_err),
    .s_req(n_s_req), .s_we(n_s_we), .s_width(n_s_width),
    .s_addr(n_s_addr), .s_wdata(n_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(n_grant), .busy(n_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g [4];

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b0; req = '0; we = '0; width = '0;
    addr = '0; wdata = '0; s_rdata = '0; s_ack = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_sreq", 64'(s_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_saddr", 64'(s_addr), 64'd0);
    tick(); tick();
    reset = 1'b0;

    // m0 word read at 0x100, slave answers 2 cycles after s_req
    req = 2'b01; we = 2'b00; width = {2'b00, W_WORD};
    addr = {32'h0, 32'h100};
    tick();
    chk("rd_sreq", 64'(s_req), 64'd1);
    chk("rd_grant", 64'(grant), 64'd1);
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_saddr", 64'(s_addr), 64'h100);
    chk("rd_swe", 64'(s_we), 64'd0);
    chk("rd_swidth", 64'(s_width), 64'd2);
    tick();
    chk("rd_ack_early", 64'(ack), 64'd0);
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    tick();
    s_ack = 1'b0; req = 2'b00;
    chk("rd_ack", 64'(ack), 64'd1);
    chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("rd_err", 64'(err), 64'd0);
    chk("rd_sreq_off", 64'(s_req), 64'd0);
    tick();
    chk("rd_ack_1cyc", 64'(ack), 64'd0);
    chk("rd_idle_busy", 64'(busy), 64'd0);
    chk("rd_idle_grant", 64'(grant), 64'd0);

    // m1 byte write at 0x2000, req dropped mid-access
    req = 2'b10; we = 2'b10; width = {W_BYTE, W_WORD};
    addr = {32'h2000, 32'h44};
    wdata = {32'h12345678, 32'h99};
    tick();
    chk("wr_grant", 64'(grant), 64'd2);
    chk("wr_swe", 64'(s_we), 64'd1);
    chk("wr_saddr", 64'(s_addr), 64'h2000);
    chk("wr_swdata", 64'(s_wdata), 64'h12345678);
    chk("wr_swidth", 64'(s_width), 64'd0);
    req = 2'b00; addr = '1; wdata = '0; we = 2'b00; width = 4'hF;
    tick();
    chk("wr_hold_addr", 64'(s_addr), 64'h2000);
    chk("wr_hold_data", 64'(s_wdata), 64'h12345678);
    chk("wr_hold_we", 64'(s_we), 64'd1);
    chk("wr_hold_width", 64'(s_width), 64'd0);
    chk("wr_hold_sreq", 64'(s_req), 64'd1);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    chk("wr_ack", 64'(ack), 64'd2);
    chk("wr_err", 64'(err), 64'd0);
    tick();

    // both masters continuously, m0 width 3 passes through
    req = 2'b11; we = 2'b00; width = {W_HALF, 2'b11};
    addr = {32'hB0, 32'hA0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tie_grant%0d", i), 64'(grant), 64'(exp_g[i]));
      chk($sformatf("tie_width%0d", i), 64'(s_width),
          exp_g[i][1] ? 64'd1 : 64'd3);
      s_ack = 1'b1; s_rdata = 32'h1000 + i;
      tick();
      s_ack = 1'b0;
      chk($sformatf("tie_ack%0d", i), 64'(ack), 64'(exp_g[i]));
      chk($sformatf("tie_rdata%0d", i), 64'(rdata), 64'h1000 + i);
      tick();
    end
    req = 2'b00;
    tick();

    // timeout: u_dut gives up after 4 cycles, u_nt keeps waiting
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h300};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_sreq%0d", i), 64'(s_req), 64'd1);
      chk($sformatf("to_noack%0d", i), 64'(ack), 64'd0);
    end
    tick();
    req = 2'b00;
    chk("to_ack", 64'(ack), 64'd1);
    chk("to_err", 64'(err), 64'd1);
    chk("to_rdata", 64'(rdata), 64'hFFFFFFFF);
    chk("to_sreq_off", 64'(s_req), 64'd0);
    tick();
    chk("to_err_1cyc", 64'(err), 64'd0);
    chk("to_idle", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("nt_sreq", 64'(n_s_req), 64'd1);
    chk("nt_noack", 64'(n_ack), 64'd0);
    // s_ack here lands in IDLE for u_dut, in ACCESS for u_nt
    s_ack = 1'b1; s_rdata = 32'h5555AAAA;
    tick();
    s_ack = 1'b0;
    chk("idle_sack_ack", 64'(ack), 64'd0);
    chk("idle_sack_busy", 64'(busy), 64'd0);
    chk("nt_ack", 64'(n_ack), 64'd1);
    chk("nt_err", 64'(n_err), 64'd0);
    chk("nt_rdata", 64'(n_rdata), 64'h5555AAAA);
    tick();

    // s_ack on the same cycle the timeout would fire
    req = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    req = 2'b00;
    s_ack = 1'b1; s_rdata = 32'hA5A5A5A5;
    tick();
    s_ack = 1'b0;
    chk("co_ack", 64'(ack), 64'd1);
    chk("co_err", 64'(err), 64'd0);
    chk("co_rdata", 64'(rdata), 64'hA5A5A5A5);
    tick();

    // reset in the middle of an access
    req = 2'b01;
    tick();
    chk("mr_sreq_pre", 64'(s_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_sreq", 64'(s_req), 64'd0);
    chk("mr_grant", 64'(grant), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    req = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk("mr_noack0", 64'(ack), 64'd0);
    tick();
    chk("mr_noack1", 64'(ack), 64'd0);
    chk("mr_noerr", 64'(err), 64'd0);
    req = 2'b10; we = 2'b10; wdata = {32'hCAFE0001, 32'h0};
    addr = {32'h400, 32'h0};
    tick();
    chk("post_grant", 64'(grant), 64'd2);
    chk("post_swdata", 64'(s_wdata), 64'hCAFE0001);
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0; req = 2'b00;
    chk("post_ack", 64'(ack), 64'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
